// File: rtl/key_event_sched.sv
// Key event scheduler: press-edge detection, typematic auto-repeat and round-robin
// arbitration of pending keys into a single ready / read-request event stream.
module key_event_sched #(
    parameter int                 KEY_CNT     = 24,
    parameter int                 TICK_DIV    = 25000,
    parameter int                 REPEAT_DLY  = 300,
    parameter int                 REPEAT_PER  = 80,
    parameter logic [KEY_CNT-1:0] REPEAT_MASK = {KEY_CNT{1'b1}},
    localparam int                KEY_W       = $clog2(KEY_CNT)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [KEY_CNT-1:0] key_i,
    input  logic               event_rd_req_i,
    output logic [KEY_W-1:0]   event_code_o,
    output logic               event_ready_o
);

    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);
    localparam logic [KEY_W-1:0] KEY_LAST = KEY_W'(KEY_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    logic [KEY_CNT-1:0] key_d;
    logic [KEY_CNT-1:0] pend;
    logic [KEY_CNT-1:0] pend_d;
    logic [KEY_CNT-1:0] press;
    logic [KEY_CNT-1:0] rep_press;
    logic [KEY_CNT-1:0] clr_vec;
    logic [KEY_CNT-1:0] fire_vec;
    logic [KEY_W-1:0]   rr_ptr;
    logic [PRE_W-1:0]   pre;
    logic               tick;
    logic               slot_free;
    logic               load;
    logic               grant_vld;
    logic [KEY_W-1:0]   grant_idx;
    logic               rep_vld;
    logic [KEY_W-1:0]   rep_idx;

    rep_state_t         state_q, state_d;
    logic [KEY_W-1:0]   trk_q, trk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fire;

    // Key index reached by stepping `off` places forward from `base`, wrapping at KEY_CNT.
    function automatic logic [KEY_W-1:0] rot(input logic [KEY_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= KEY_CNT) sum = sum - KEY_CNT;
        return KEY_W'(sum);
    endfunction

    assign press     = key_i & ~key_d;
    assign rep_press = press & REPEAT_MASK;
    assign tick      = (pre == PRE_LAST);
    assign slot_free = ~event_ready_o | event_rd_req_i;
    assign load      = slot_free & grant_vld;
    assign clr_vec   = load ? (KEY_CNT'(1) << grant_idx) : '0;
    assign fire_vec  = fire ? (KEY_CNT'(1) << trk_q) : '0;
    // A set arriving in the same cycle as the grant clear wins, so the key stays pending.
    assign pend_d    = (pend & ~clr_vec) | press | fire_vec;

    // Scanning from the far end lets the closest pending key after rr_ptr be the last writer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = KEY_CNT - 1; i >= 0; i--) begin
            if (pend[rot(rr_ptr, i)]) begin
                grant_vld = 1'b1;
                grant_idx = rot(rr_ptr, i);
            end
        end
    end

    always_comb begin
        rep_vld = |rep_press;
        rep_idx = '0;
        for (int i = KEY_CNT - 1; i >= 0; i--) begin
            if (rep_press[i]) rep_idx = KEY_W'(i);
        end
    end

    // Repeat FSM next state: a fresh press retargets; otherwise release beats a due fire.
    always_comb begin
        state_d = state_q;
        trk_d   = trk_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        if (rep_vld) begin
            state_d = DELAY;
            trk_d   = rep_idx;
            cnt_d   = '0;
        end else if (state_q != IDLE) begin
            if (!key_i[trk_q]) begin
                state_d = IDLE;
            end else if (tick) begin
                if (cnt_q == ((state_q == DELAY) ? DLY_LAST : PER_LAST)) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            trk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples
            // pre-edge values and the order of statements cannot change the result.
            state_q <= state_d;
            trk_q   <= trk_d;
            cnt_q   <= cnt_d;
        end
    end

    // All-ones key history hides keys already held when reset is released.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_d         <= '1;
            pend          <= '0;
            rr_ptr        <= '0;
            pre           <= '0;
            event_ready_o <= 1'b0;
            event_code_o  <= '0;
        end else begin
            key_d <= key_i;
            pend  <= pend_d;
            pre   <= tick ? '0 : pre + 1'b1;
            if (slot_free) begin
                event_ready_o <= grant_vld;
                if (grant_vld) begin
                    event_code_o <= grant_idx;
                    rr_ptr       <= (grant_idx == KEY_LAST) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_event_sched.sv
// Self-checking bench for key_event_sched: directed scenarios plus random key/read
// traffic, all compared against an event-level reference model kept in this file.
module tb_key_event_sched;

    localparam int                 KEY_CNT     = 24;
    localparam int                 KEY_W       = 5;
    localparam int                 TICK_DIV    = 2;
    localparam int                 REPEAT_DLY  = 5;
    localparam int                 REPEAT_PER  = 3;
    localparam logic [KEY_CNT-1:0] REPEAT_MASK = 24'hFFFFBF;

    logic               clk;
    logic               rst;
    logic [KEY_CNT-1:0] key;
    logic               rd_req;
    logic [KEY_W-1:0]   code;
    logic               ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [KEY_CNT-1:0] m_keyd;
    bit [KEY_CNT-1:0] m_pend;
    int               m_rr;
    int               m_pre;
    bit               m_trk_on;
    int               m_trk;
    int               m_ticks;
    bit               m_ready;
    logic [KEY_W-1:0] m_code;

    key_event_sched #(
        .KEY_CNT    (KEY_CNT),
        .TICK_DIV   (TICK_DIV),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER),
        .REPEAT_MASK(REPEAT_MASK)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .key_i         (key),
        .event_rd_req_i(rd_req),
        .event_code_o  (code),
        .event_ready_o (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of the specified behaviour; repeat timing is counted in ticks since tracking began.
    function automatic void model_update(input logic [KEY_CNT-1:0] k, input bit rd, input bit r);
        bit               tick;
        bit [KEY_CNT-1:0] press;
        bit [KEY_CNT-1:0] clr;
        bit [KEY_CNT-1:0] fire_v;
        int               g;
        if (r) begin
            m_keyd = '1; m_pend = '0; m_rr = 0; m_pre = 0;
            m_trk_on = 1'b0; m_trk = 0; m_ticks = 0; m_ready = 1'b0; m_code = '0;
            return;
        end
        tick   = (m_pre == TICK_DIV - 1);
        m_pre  = (m_pre + 1) % TICK_DIV;
        press  = k & ~m_keyd;
        clr    = '0;
        fire_v = '0;
        if (!m_ready || rd) begin
            g = -1;
            for (int i = 0; i < KEY_CNT; i++)
                if (g < 0 && m_pend[KEY_W'((m_rr + i) % KEY_CNT)]) g = (m_rr + i) % KEY_CNT;
            if (g >= 0) begin
                m_ready = 1'b1;
                m_code  = KEY_W'(g);
                m_rr    = (g + 1) % KEY_CNT;
                clr[KEY_W'(g)] = 1'b1;
            end else begin
                m_ready = 1'b0;
            end
        end
        if ((press & REPEAT_MASK) != 0) begin
            for (int i = KEY_CNT - 1; i >= 0; i--)
                if (press[i] && REPEAT_MASK[i]) m_trk = i;
            m_trk_on = 1'b1;
            m_ticks  = 0;
        end else if (m_trk_on) begin
            if (!k[KEY_W'(m_trk)]) begin
                m_trk_on = 1'b0;
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == REPEAT_DLY ||
                    (m_ticks > REPEAT_DLY && (m_ticks - REPEAT_DLY) % REPEAT_PER == 0))
                    fire_v[KEY_W'(m_trk)] = 1'b1;
            end
        end
        m_pend = (m_pend & ~clr) | press | fire_v;
        m_keyd = k;
    endfunction

    // Drive one cycle of inputs from a falling edge and return at the next falling edge.
    task automatic step(input logic [KEY_CNT-1:0] k, input bit rd, input bit r = 1'b0);
        key    = k;
        rd_req = rd;
        rst    = r;
        model_update(k, rd, r);
        @(negedge clk);
    endtask

    function automatic logic [KEY_CNT-1:0] kb(input int idx);
        return KEY_CNT'(1) << idx;
    endfunction

    task automatic test_reset();
        logic [KEY_CNT-1:0] k3;
        k3 = kb(3);
        step(k3, 1'b0, 1'b1);
        step(k3, 1'b0, 1'b1);
        checks++;
        if (ready !== 1'b0 || code !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%0b code=%0d expected ready=0 code=0", ready, code);
        end
        for (int i = 0; i < 8; i++) begin
            step((i < 6) ? k3 : '0, 1'b0);
            checks++;
            if (ready !== 1'b0 || ready !== m_ready) begin
                errors++;
                $display("FAIL reset_held_key: ready=%0b expected 0 (cycle %0d)", ready, i);
            end
        end
        step(k3, 1'b0);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency_n1: ready=%0b expected 0", ready);
        end
        step(k3, 1'b0);
        checks++;
        if (ready !== 1'b1 || code !== 5'd3) begin
            errors++;
            $display("FAIL reset_latency_n2: ready=%0b code=%0d expected ready=1 code=3", ready, code);
        end
        step(k3, 1'b1);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pop: ready=%0b expected 0", ready);
        end
        step('0, 1'b1);
        step('0, 1'b1);
    endtask

    task automatic test_round_robin();
        logic [KEY_CNT-1:0] kv;
        int                 exp_r[4];
        int                 exp_c[4];
        step('0, 1'b0, 1'b1);
        step('0, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            kv = (pass == 0) ? (kb(5) | kb(2)) : (kb(7) | kb(2));
            exp_r = '{0, 1, 1, 0};
            exp_c = (pass == 0) ? '{0, 2, 5, 0} : '{0, 7, 2, 0};
            for (int i = 0; i < 4; i++) begin
                step(kv, 1'b1);
                checks++;
                if (ready !== exp_r[i][0] || (exp_r[i] == 1 && code !== KEY_W'(exp_c[i])) ||
                    ready !== m_ready || (m_ready && code !== m_code)) begin
                    errors++;
                    $display("FAIL round_robin pass%0d cyc%0d: ready=%0b code=%0d expected ready=%0d code=%0d",
                             pass, i, ready, code, exp_r[i], exp_c[i]);
                end
            end
            step('0, 1'b1);
            step('0, 1'b1);
        end
    endtask

    task automatic test_auto_repeat();
        int ev[$];
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        for (int i = 1; i <= 45; i++) begin
            step(kb(4), 1'b1);
            checks++;
            if (ready !== m_ready || (ready === 1'b1 && code !== 5'd4)) begin
                errors++;
                $display("FAIL repeat_hold cyc%0d: ready=%0b code=%0d expected ready=%0b code=4",
                         i, ready, code, m_ready);
            end
            if (ready === 1'b1) ev.push_back(i);
        end
        checks++;
        if (ev.size() < 5 || ev[0] != 2) begin
            errors++;
            $display("FAIL repeat_first: events=%0d first_at=%0d expected >=5 events first_at=2",
                     ev.size(), (ev.size() > 0) ? ev[0] : -1);
        end else begin
            checks++;
            if (ev[1] - ev[0] < 2 * REPEAT_DLY - 1 || ev[1] - ev[0] > 2 * REPEAT_DLY) begin
                errors++;
                $display("FAIL repeat_delay: gap=%0d expected 9..10", ev[1] - ev[0]);
            end
            for (int j = 2; j < ev.size(); j++) begin
                checks++;
                if (ev[j] - ev[j-1] != TICK_DIV * REPEAT_PER) begin
                    errors++;
                    $display("FAIL repeat_period: gap=%0d expected 6", ev[j] - ev[j-1]);
                end
            end
        end
        for (int i = 0; i < 30; i++) begin
            step('0, 1'b1);
            checks++;
            if (ready !== m_ready || (i >= 1 && ready !== 1'b0)) begin
                errors++;
                $display("FAIL repeat_release cyc%0d: ready=%0b expected %0b", i, ready, m_ready);
            end
        end
    endtask

    task automatic test_blocked();
        int n9;
        step('0, 1'b0, 1'b1);
        step('0, 1'b0);
        step(kb(1) | kb(2) | kb(3), 1'b0);
        step('0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (ready !== 1'b1 || code !== 5'd1 || ready !== m_ready) begin
                errors++;
                $display("FAIL blocked_stable cyc%0d: ready=%0b code=%0d expected ready=1 code=1",
                         i, ready, code);
            end
            step('0, 1'b0);
        end
        step('0, 1'b1);
        checks++;
        if (ready !== 1'b1 || code !== 5'd2) begin
            errors++;
            $display("FAIL blocked_b2b_first: ready=%0b code=%0d expected ready=1 code=2", ready, code);
        end
        step('0, 1'b1);
        checks++;
        if (ready !== 1'b1 || code !== 5'd3) begin
            errors++;
            $display("FAIL blocked_b2b_second: ready=%0b code=%0d expected ready=1 code=3", ready, code);
        end
        step('0, 1'b1);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL blocked_drain: ready=%0b expected 0", ready);
        end
        step(kb(0), 1'b0);
        step('0, 1'b0);
        step(kb(9), 1'b0);
        step('0, 1'b0);
        step(kb(9), 1'b0);
        step('0, 1'b0);
        checks++;
        if (ready !== 1'b1 || code !== 5'd0) begin
            errors++;
            $display("FAIL blocked_holder: ready=%0b code=%0d expected ready=1 code=0", ready, code);
        end
        n9 = 0;
        for (int i = 0; i < 8; i++) begin
            step('0, 1'b1);
            checks++;
            if (ready !== m_ready || (m_ready && code !== m_code)) begin
                errors++;
                $display("FAIL blocked_model cyc%0d: ready=%0b code=%0d expected ready=%0b code=%0d",
                         i, ready, code, m_ready, m_code);
            end
            if (ready === 1'b1 && code === 5'd9) n9++;
        end
        checks++;
        if (n9 != 1) begin
            errors++;
            $display("FAIL blocked_coalesce: code9_events=%0d expected 1", n9);
        end
    endtask

    task automatic test_no_repeat_mask();
        int n;
        int n6;
        n  = 0;
        n6 = 0;
        for (int i = 0; i < 100; i++) begin
            step(kb(6), 1'b1);
            checks++;
            if (ready !== m_ready || (m_ready && code !== m_code)) begin
                errors++;
                $display("FAIL norepeat_model cyc%0d: ready=%0b code=%0d expected ready=%0b code=%0d",
                         i, ready, code, m_ready, m_code);
            end
            if (ready === 1'b1) n++;
            if (ready === 1'b1 && code === 5'd6) n6++;
        end
        checks++;
        if (n != 1 || n6 != 1) begin
            errors++;
            $display("FAIL norepeat_count: events=%0d code6=%0d expected 1 and 1", n, n6);
        end
        step('0, 1'b1);
        step('0, 1'b1);
    endtask

    task automatic test_reset_mid();
        step(kb(4), 1'b0);
        for (int i = 0; i < 25; i++) step(kb(4), 1'b0);
        checks++;
        if (ready !== 1'b1 || code !== 5'd4 || m_pend[4] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: ready=%0b code=%0d expected ready=1 code=4", ready, code);
        end
        step(kb(4), 1'b0, 1'b1);
        checks++;
        if (ready !== 1'b0 || code !== 5'd0) begin
            errors++;
            $display("FAIL midreset_state: ready=%0b code=%0d expected ready=0 code=0", ready, code);
        end
        for (int i = 0; i < 30; i++) begin
            step(kb(4), 1'b1);
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL midreset_held cyc%0d: ready=%0b expected 0", i, ready);
            end
        end
        step('0, 1'b1);
        step(kb(4), 1'b1);
        step(kb(4), 1'b1);
        checks++;
        if (ready !== 1'b1 || code !== 5'd4) begin
            errors++;
            $display("FAIL midreset_repress: ready=%0b code=%0d expected ready=1 code=4", ready, code);
        end
        step('0, 1'b1);
        step('0, 1'b1);
    endtask

    task automatic test_random();
        logic [KEY_CNT-1:0] kv;
        logic [KEY_W-1:0]   idx;
        bit                 rd;
        bit                 r;
        kv = '0;
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                idx = KEY_W'($urandom_range(0, KEY_CNT - 1));
                kv[idx] = ~kv[idx];
            end
            if ($urandom_range(0, 40) == 0) kv = KEY_CNT'($urandom);
            rd = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 399) == 0);
            step(kv, rd, r);
            checks++;
            if (ready !== m_ready || (m_ready && code !== m_code)) begin
                errors++;
                $display("FAIL random cyc%0d: ready=%0b code=%0d expected ready=%0b code=%0d",
                         i, ready, code, m_ready, m_code);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        key    = '0;
        rd_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_auto_repeat();
        test_blocked();
        test_no_repeat_mask();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
